// File: rtl/ave_arbiter_seq.sv
// Round-robin shared averaging engine: the granted source streams N_SAMPLES signed
// samples, the sum is divided by N_SAMPLES in a serial restoring divider, and the result is returned tagged with the source ID.
module ave_arbiter_seq #(
  parameter int NUM_REQ   = 4,
  parameter int N_SAMPLES = 7,
  parameter int W         = 32,
  parameter int IDW       = 2,
  parameter int ACC_W     = 35
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*W-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [W-1:0]         m_avg,
  output logic [IDW-1:0]       m_id,
  output logic                 busy
);

  localparam int CNT_W  = $clog2(N_SAMPLES + 1);
  localparam int DCNT_W = $clog2(ACC_W + 1);

  localparam logic [ACC_W-1:0]  DIVISOR   = ACC_W'(N_SAMPLES);
  localparam logic [ACC_W-1:0]  ACC_ONE   = ACC_W'(1'b1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(N_SAMPLES - 1);
  localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1'b1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(ACC_W);
  localparam logic [IDW-1:0]    ID_ONE    = IDW'(1'b1);
  localparam logic [IDW-1:0]    ID_LAST   = IDW'(NUM_REQ - 1);
  localparam logic [IDW:0]      NREQ_EXT  = (IDW+1)'(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DIVIDE  = 2'd2,
    OUT     = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [IDW-1:0]       gnt_id_q, gnt_id_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DCNT_W-1:0]    dcnt_q, dcnt_d;
  logic [ACC_W-1:0]     dvd_q, dvd_d;
  logic [ACC_W-1:0]     rem_q, rem_d;
  logic                 neg_q, neg_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic                 m_valid_q, m_valid_d;
  logic [W-1:0]         m_avg_q, m_avg_d;
  logic [IDW-1:0]       m_id_q, m_id_d;
  logic                 busy_q, busy_d;

  logic                 arb_hit_s;
  logic [IDW-1:0]       arb_idx_s;
  logic [IDW:0]         cand_sum_s;
  logic [IDW-1:0]       cand_s;
  logic [W-1:0]         sample_s;
  logic [ACC_W-1:0]     acc_sum_s;
  logic [ACC_W-1:0]     acc_abs_s;
  logic [ACC_W-1:0]     rem_shift_s;
  logic                 rem_ge_s;
  logic [ACC_W-1:0]     quo_signed_s;

  // Round-robin search: first requesting index at or after rr pointer, wrapping.
  always_comb begin
    arb_hit_s  = 1'b0;
    arb_idx_s  = '0;
    cand_sum_s = '0;
    cand_s     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_sum_s = {1'b0, rr_ptr_q} + (IDW+1)'(i);
      cand_s     = (cand_sum_s >= NREQ_EXT) ? IDW'(cand_sum_s - NREQ_EXT) : IDW'(cand_sum_s);
      arb_idx_s  = (!arb_hit_s && req_valid[cand_s]) ? cand_s : arb_idx_s;
      arb_hit_s  = arb_hit_s | req_valid[cand_s];
    end
  end

  // Datapath helpers: accumulate, magnitude, one divider step, signed quotient.
  always_comb begin
    sample_s     = req_data[int'(gnt_id_q) * W +: W];
    acc_sum_s    = acc_q + {{(ACC_W-W){sample_s[W-1]}}, sample_s};
    acc_abs_s    = acc_sum_s[ACC_W-1] ? (~acc_sum_s + ACC_ONE) : acc_sum_s;
    rem_shift_s  = {rem_q[ACC_W-2:0], dvd_q[ACC_W-1]};
    rem_ge_s     = (rem_shift_s >= DIVISOR);
    quo_signed_s = neg_q ? (~dvd_q + ACC_ONE) : dvd_q;
  end

  // Next-state and register-input logic for the arbitration/collect/divide/output sequence.
  always_comb begin
    state_d     = state_q;
    gnt_id_d    = gnt_id_q;
    rr_ptr_d    = rr_ptr_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    dcnt_d      = dcnt_q;
    dvd_d       = dvd_q;
    rem_d       = rem_q;
    neg_d       = neg_q;
    req_ready_d = req_ready_q;
    m_valid_d   = m_valid_q;
    m_avg_d     = m_avg_q;
    m_id_d      = m_id_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (arb_hit_s) begin
          state_d     = COLLECT;
          gnt_id_d    = arb_idx_s;
          req_ready_d = NUM_REQ'(1'b1) << arb_idx_s;
          busy_d      = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      COLLECT: begin
        if (req_valid[gnt_id_q] && req_ready_q[gnt_id_q]) begin
          acc_d = acc_sum_s;
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            // Last sample: load the divider straight from the final sum.
            state_d     = DIVIDE;
            req_ready_d = '0;
            dvd_d       = acc_abs_s;
            rem_d       = '0;
            neg_d       = acc_sum_s[ACC_W-1];
            dcnt_d      = '0;
          end else begin
            state_d = COLLECT;
          end
        end else begin
          state_d = COLLECT;
        end
      end
      DIVIDE: begin
        if (dcnt_q == DCNT_LAST) begin
          state_d   = OUT;
          m_valid_d = 1'b1;
          m_avg_d   = quo_signed_s[W-1:0];
          m_id_d    = gnt_id_q;
        end else begin
          dcnt_d = dcnt_q + DCNT_ONE;
          rem_d  = rem_ge_s ? (rem_shift_s - DIVISOR) : rem_shift_s;
          dvd_d  = {dvd_q[ACC_W-2:0], rem_ge_s};
        end
      end
      OUT: begin
        if (m_ready) begin
          state_d   = IDLE;
          m_valid_d = 1'b0;
          rr_ptr_d  = (gnt_id_q == ID_LAST) ? '0 : (gnt_id_q + ID_ONE);
          acc_d     = '0;
          cnt_d     = '0;
          busy_d    = 1'b0;
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = '0;
        m_valid_d   = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_id_q    <= '0;
      rr_ptr_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      dcnt_q      <= '0;
      dvd_q       <= '0;
      rem_q       <= '0;
      neg_q       <= 1'b0;
      req_ready_q <= '0;
      m_valid_q   <= 1'b0;
      m_avg_q     <= '0;
      m_id_q      <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_id_q    <= gnt_id_d;
      rr_ptr_q    <= rr_ptr_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      dcnt_q      <= dcnt_d;
      dvd_q       <= dvd_d;
      rem_q       <= rem_d;
      neg_q       <= neg_d;
      req_ready_q <= req_ready_d;
      m_valid_q   <= m_valid_d;
      m_avg_q     <= m_avg_d;
      m_id_q      <= m_id_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready = req_ready_q;
  assign m_valid   = m_valid_q;
  assign m_avg     = m_avg_q;
  assign m_id      = m_id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ave_arbiter_seq.sv
// Bench for ave_arbiter_seq: directed vector table, multi-cycle corner sequences and
// random traffic, all checked against a cycle-level reference model of the averaging protocol.
`timescale 1ns/1ps
module tb_ave_arbiter_seq;
  localparam int NUM_REQ   = 4;
  localparam int N_SAMPLES = 7;
  localparam int W         = 32;
  localparam int IDW       = 2;
  localparam int ACC_W     = 35;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*W-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 m_valid;
  logic                 m_ready;
  logic [W-1:0]         m_avg;
  logic [IDW-1:0]       m_id;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ave_arbiter_seq #(.NUM_REQ(NUM_REQ), .N_SAMPLES(N_SAMPLES), .W(W), .IDW(IDW), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .m_valid(m_valid), .m_ready(m_ready), .m_avg(m_avg), .m_id(m_id), .busy(busy)
  );

  function automatic void chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model (advanced once per cycle at negedge) ----------------
  int      mdl_ptr, mdl_gid, mdl_nsamp, mdl_cd, mdl_avg;
  bit      mdl_busy, mdl_found, exp_mv;
  longint  mdl_sum;
  logic [NUM_REQ-1:0] exp_rdy;
  int      hs_ids[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      mdl_ptr = 0; mdl_busy = 0; mdl_nsamp = 0; mdl_sum = 0; mdl_cd = 0;
    end else begin
      if (mdl_cd > 0) mdl_cd--;
      exp_rdy = (mdl_busy && mdl_nsamp < N_SAMPLES) ? (NUM_REQ'(1) << mdl_gid) : '0;
      exp_mv  = mdl_busy && (mdl_nsamp == N_SAMPLES) && (mdl_cd == 0);
      chk(busy === mdl_busy, "busy", longint'(busy), longint'(mdl_busy));
      chk(req_ready === exp_rdy, "req_ready", longint'(req_ready), longint'(exp_rdy));
      chk(m_valid === exp_mv, "m_valid", longint'(m_valid), longint'(exp_mv));
      if (exp_mv && m_valid) begin
        chk(m_avg === mdl_avg, "model_avg", longint'($signed(m_avg)), longint'(mdl_avg));
        chk(m_id === IDW'(mdl_gid), "model_id", longint'(m_id), longint'(mdl_gid));
      end
      if (exp_rdy != '0 && req_valid[mdl_gid]) begin
        mdl_sum += longint'($signed(req_data[mdl_gid*W +: W]));
        mdl_nsamp++;
        if (mdl_nsamp == N_SAMPLES) begin
          mdl_avg = int'(mdl_sum / N_SAMPLES);
          // accepting edge plus ACC_W+1 further edges until m_valid is visible
          mdl_cd  = ACC_W + 2;
        end
      end
      if (exp_mv && m_ready) begin
        hs_ids.push_back(int'(m_id));
        mdl_ptr   = (mdl_gid + 1) % NUM_REQ;
        mdl_busy  = 0; mdl_nsamp = 0; mdl_sum = 0;
      end else if (!mdl_busy && req_valid != '0) begin
        mdl_found = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
          if (!mdl_found && req_valid[(mdl_ptr + k) % NUM_REQ]) begin
            mdl_gid = (mdl_ptr + k) % NUM_REQ;
            mdl_found = 1;
          end
        end
        mdl_busy = 1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  typedef struct {
    int src;
    int samp [N_SAMPLES];
    int avg;
  } vec_t;

  vec_t vecs [8];
  int   smp  [N_SAMPLES];

  function automatic void setv(input int i, input int src, input int a0, input int a1, input int a2,
                               input int a3, input int a4, input int a5, input int a6, input int avg);
    vecs[i].src = src;
    vecs[i].samp[0] = a0; vecs[i].samp[1] = a1; vecs[i].samp[2] = a2; vecs[i].samp[3] = a3;
    vecs[i].samp[4] = a4; vecs[i].samp[5] = a5; vecs[i].samp[6] = a6;
    vecs[i].avg = avg;
  endfunction

  task automatic send_burst(input int src, input int s [N_SAMPLES], input int n,
                            input int stall_at, input int stall_len);
    bit hs;
    for (int k = 0; k < n; k++) begin
      if (k == stall_at) begin
        req_valid[src] = 1'b0;
        repeat (stall_len) @(posedge clk);
        #1;
      end
      req_valid[src] = 1'b1;
      req_data[src*W +: W] = s[k];
      hs = 0;
      for (int t = 0; t < 200 && !hs; t++) begin
        @(negedge clk);
        hs = req_ready[src];
        @(posedge clk);
        #1;
      end
      chk(hs, "accept_timeout", longint'(hs), 1);
    end
    req_valid[src] = 1'b0;
  endtask

  task automatic wait_result(input int exp_avg, input int exp_id, input bit pre_ready, input int hold);
    bit seen;
    seen = 0;
    m_ready = pre_ready;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      seen = m_valid;
    end
    chk(seen, "result_timeout", longint'(seen), 1);
    if (seen) begin
      chk(m_avg === exp_avg, "avg", longint'($signed(m_avg)), longint'(exp_avg));
      chk(m_id === IDW'(exp_id), "id", longint'(m_id), longint'(exp_id));
      for (int h = 0; h < hold; h++) begin
        @(posedge clk);
        #1;
        chk(m_valid === 1'b1 && m_avg === exp_avg && m_id === IDW'(exp_id), "hold",
            longint'($signed(m_avg)), longint'(exp_avg));
      end
      if (!pre_ready) begin
        @(posedge clk);
        #1;
        m_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      chk(m_valid === 1'b0, "m_valid_drop", longint'(m_valid), 0);
    end
    m_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk(req_ready === '0, {tag, "_req_ready"}, longint'(req_ready), 0);
    chk(m_valid === 1'b0, {tag, "_m_valid"}, longint'(m_valid), 0);
    chk(m_avg === '0, {tag, "_m_avg"}, longint'(m_avg), 0);
    chk(m_id === '0, {tag, "_m_id"}, longint'(m_id), 0);
    chk(busy === 1'b0, {tag, "_busy"}, longint'(busy), 0);
  endtask

  int base;
  logic [W-1:0] rv;

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; m_ready = 1'b0;
    setv(0, 0, 1, 2, 3, 4, 5, 6, 7, 4);
    setv(1, 2, -8, 0, 0, 0, 0, 0, 0, -1);
    setv(2, 2, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
         32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    setv(3, 2, int'(32'h8000_0000), int'(32'h8000_0000), int'(32'h8000_0000), int'(32'h8000_0000),
         int'(32'h8000_0000), int'(32'h8000_0000), int'(32'h8000_0000), int'(32'h8000_0000));
    setv(4, 1, -6, 0, 0, 0, 0, 0, 0, 0);
    setv(5, 3, 8, 0, 0, 0, 0, 0, 0, 1);
    setv(6, 1, 10, 20, 30, 40, 50, 60, -11, 28);
    setv(7, 3, -10, -20, -30, -40, -50, -60, 11, -28);

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // all sources requesting continuously: grants rotate 0,1,2,3,...
    base = hs_ids.size();
    req_valid = '1;
    m_ready = 1'b1;
    for (int t = 0; t < 2000 && hs_ids.size() < base + 8; t++) begin
      for (int i = 0; i < NUM_REQ; i++) req_data[i*W +: W] = $urandom;
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    m_ready = 1'b0;
    chk(hs_ids.size() == base + 8, "rr_bursts", longint'(hs_ids.size() - base), 8);
    for (int k = 0; k < 8; k++) begin
      if (base + k < hs_ids.size())
        chk(hs_ids[base + k] == k % NUM_REQ, "rr_order", longint'(hs_ids[base + k]), longint'(k % NUM_REQ));
    end

    // directed vector table, m_ready held high ahead of the result
    for (int v = 0; v < 8; v++) begin
      send_burst(vecs[v].src, vecs[v].samp, N_SAMPLES, -1, 0);
      wait_result(vecs[v].avg, vecs[v].src, 1'b1, 0);
    end

    // stall after sample 3, then back-pressure for 10 cycles in OUT
    base = hs_ids.size();
    smp = '{5, 10, 15, 20, 25, 30, 35};
    send_burst(1, smp, N_SAMPLES, 3, 5);
    wait_result(20, 1, 1'b0, 10);
    chk(hs_ids.size() == base + 1, "one_handshake", longint'(hs_ids.size() - base), 1);

    // reset during COLLECT with four samples taken
    smp = '{100, 200, 300, 400, 500, 600, 700};
    send_burst(3, smp, 4, -1, 0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_collect");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset during DIVIDE
    smp = '{7, 7, 7, 7, 7, 7, 7};
    send_burst(0, smp, N_SAMPLES, -1, 0);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_divide");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    smp = '{-1, -2, -3, -4, -5, -6, -7};
    send_burst(2, smp, N_SAMPLES, -1, 0);
    wait_result(-4, 2, 1'b1, 0);

    // random traffic against the model
    base = hs_ids.size();
    for (int t = 0; t < 4000; t++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        case ($urandom_range(0, 7))
          0: rv = 32'h7FFF_FFFF;
          1: rv = 32'h8000_0000;
          2: rv = 32'hFFFF_FFFF;
          default: rv = $urandom;
        endcase
        req_data[i*W +: W] = rv;
        req_valid[i] = ($urandom_range(0, 9) < 7);
      end
      m_ready = ($urandom_range(0, 1) == 1);
      @(posedge clk);
      #1;
    end
    m_ready = 1'b1;
    for (int t = 0; t < 500 && busy; t++) begin
      req_valid = req_ready;
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    m_ready = 1'b0;
    chk(busy === 1'b0, "drain", longint'(busy), 0);
    chk(hs_ids.size() > base + 10, "random_bursts", longint'(hs_ids.size() - base), 11);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
